// File: rtl/null_src_sink.sv
// Null source/sink with loopback and 64-bit traffic counters behind a ctrlport register map.
// The source emits a line-indexed pattern. The sink accepts and discards everything.
module null_src_sink #(
  parameter int CHDR_W = 64,
  parameter int NSPC   = 2,
  parameter int ITEM_W = 32,
  parameter int MTU    = 10
) (
  input  logic              rfnoc_chdr_clk,
  input  logic              rfnoc_chdr_rst_n,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic [CHDR_W-1:0] s_snk_tdata,
  input  logic              s_snk_tlast,
  input  logic              s_snk_tvalid,
  output logic              s_snk_tready,
  output logic [CHDR_W-1:0] m_src_tdata,
  output logic              m_src_tlast,
  output logic              m_src_tvalid,
  input  logic              m_src_tready,
  output logic [15:0]       m_src_tlength,
  input  logic [CHDR_W-1:0] s_loop_tdata,
  input  logic              s_loop_tlast,
  input  logic              s_loop_tvalid,
  output logic              s_loop_tready,
  output logic [CHDR_W-1:0] m_loop_tdata,
  output logic              m_loop_tlast,
  output logic              m_loop_tvalid,
  input  logic              m_loop_tready
);

  localparam logic [7:0]  NSPC_B   = 8'(NSPC);
  localparam logic [7:0]  ITEM_B   = 8'(ITEM_W);
  localparam logic [11:0] MAX_LINE = 12'((1 << MTU) - 1);

  typedef enum logic {S_IDLE, S_RUN} src_state_t;

  src_state_t  r_state;
  logic        r_src_en, r_snk_tready, r_src_tvalid, r_src_tlast;
  logic [11:0] r_lines_per_pkt, r_line, r_pkt_lines;
  logic [15:0] r_bytes_per_pkt, r_idx;
  logic        r_ack;
  logic [31:0] r_resp_data;
  logic [31:0] r_shadow [6];
  logic [63:0] r_snk_line_cnt, r_snk_pkt_cnt, r_src_line_cnt;
  logic [63:0] r_src_pkt_cnt, r_loop_line_cnt, r_loop_pkt_cnt;

  logic [63:0] w_cnt [6];
  logic        w_clr, w_snk_beat, w_src_beat, w_loop_beat, w_cnt_hit;
  logic [2:0]  w_cnt_sel;
  logic [31:0] w_rd_data;
  logic [11:0] w_lines_clamp;
  logic [63:0] w_word;
  logic        w_unused;

  assign w_clr       = s_ctrlport_req_wr && (s_ctrlport_req_addr == 20'h0) && s_ctrlport_req_data[0];
  assign w_snk_beat  = s_snk_tvalid && r_snk_tready;
  assign w_src_beat  = r_src_tvalid && m_src_tready;
  assign w_loop_beat = s_loop_tvalid && m_loop_tready;

  assign w_cnt[0] = r_snk_line_cnt;
  assign w_cnt[1] = r_snk_pkt_cnt;
  assign w_cnt[2] = r_src_line_cnt;
  assign w_cnt[3] = r_src_pkt_cnt;
  assign w_cnt[4] = r_loop_line_cnt;
  assign w_cnt[5] = r_loop_pkt_cnt;

  // Counter block spans 0x10..0x3C: addr[5:3]-2 picks the counter, addr[2] picks HI.
  assign w_cnt_hit = (s_ctrlport_req_addr[19:6] == '0) && (s_ctrlport_req_addr[5:4] != 2'b00) &&
                     (s_ctrlport_req_addr[1:0] == 2'b00);
  assign w_cnt_sel = 3'(s_ctrlport_req_addr[5:3] - 3'd2);

  always_comb begin
    w_rd_data = '0;
    if (s_ctrlport_req_addr == 20'h00)
      w_rd_data = {NSPC_B, ITEM_B, 14'b0, r_src_en, 1'b0};
    else if (s_ctrlport_req_addr == 20'h04)
      w_rd_data = {20'b0, r_lines_per_pkt};
    else if (s_ctrlport_req_addr == 20'h08)
      w_rd_data = {16'b0, r_bytes_per_pkt};
    else if (w_cnt_hit)
      w_rd_data = s_ctrlport_req_addr[2] ? r_shadow[w_cnt_sel] : w_cnt[w_cnt_sel][31:0];
  end

  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) begin
      r_ack           <= 1'b0;
      r_resp_data     <= '0;
      r_src_en        <= 1'b0;
      r_lines_per_pkt <= '0;
      r_bytes_per_pkt <= 16'd8;
      for (int unsigned k = 0; k < 6; k++) r_shadow[k] <= '0;
    end else begin
      r_ack       <= s_ctrlport_req_wr || s_ctrlport_req_rd;
      r_resp_data <= s_ctrlport_req_rd ? w_rd_data : '0;
      if (s_ctrlport_req_wr) begin
        if (s_ctrlport_req_addr == 20'h00) r_src_en        <= s_ctrlport_req_data[1];
        if (s_ctrlport_req_addr == 20'h04) r_lines_per_pkt <= s_ctrlport_req_data[11:0];
        if (s_ctrlport_req_addr == 20'h08) r_bytes_per_pkt <= s_ctrlport_req_data[15:0];
      end
      if (w_clr)
        for (int unsigned k = 0; k < 6; k++) r_shadow[k] <= '0;
      else if (s_ctrlport_req_rd && w_cnt_hit && !s_ctrlport_req_addr[2])
        r_shadow[w_cnt_sel] <= w_cnt[w_cnt_sel][63:32];
    end
  end

  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) begin
      r_snk_line_cnt  <= '0;
      r_snk_pkt_cnt   <= '0;
      r_src_line_cnt  <= '0;
      r_src_pkt_cnt   <= '0;
      r_loop_line_cnt <= '0;
      r_loop_pkt_cnt  <= '0;
    end else if (w_clr) begin
      r_snk_line_cnt  <= '0;
      r_snk_pkt_cnt   <= '0;
      r_src_line_cnt  <= '0;
      r_src_pkt_cnt   <= '0;
      r_loop_line_cnt <= '0;
      r_loop_pkt_cnt  <= '0;
    end else begin
      if (w_snk_beat)                  r_snk_line_cnt  <= r_snk_line_cnt + 64'd1;
      if (w_snk_beat && s_snk_tlast)   r_snk_pkt_cnt   <= r_snk_pkt_cnt + 64'd1;
      if (w_src_beat)                  r_src_line_cnt  <= r_src_line_cnt + 64'd1;
      if (w_src_beat && r_src_tlast)   r_src_pkt_cnt   <= r_src_pkt_cnt + 64'd1;
      if (w_loop_beat)                 r_loop_line_cnt <= r_loop_line_cnt + 64'd1;
      if (w_loop_beat && s_loop_tlast) r_loop_pkt_cnt  <= r_loop_pkt_cnt + 64'd1;
    end
  end

  assign w_lines_clamp = (r_lines_per_pkt > MAX_LINE) ? MAX_LINE : r_lines_per_pkt;

  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) begin
      r_state      <= S_IDLE;
      r_src_tvalid <= 1'b0;
      r_src_tlast  <= 1'b0;
      r_line       <= '0;
      r_pkt_lines  <= '0;
      r_idx        <= '0;
      r_snk_tready <= 1'b0;
    end else begin
      r_snk_tready <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_src_en) begin
            r_state      <= S_RUN;
            r_src_tvalid <= 1'b1;
            r_line       <= '0;
            r_pkt_lines  <= w_lines_clamp;
            r_src_tlast  <= (w_lines_clamp == '0);
          end
        end
        S_RUN: begin
          if (m_src_tready) begin
            if (r_src_tlast) begin
              r_line <= '0;
              if (r_src_en) begin
                r_pkt_lines <= w_lines_clamp;
                r_src_tlast <= (w_lines_clamp == '0);
              end else begin
                r_state      <= S_IDLE;
                r_src_tvalid <= 1'b0;
                r_src_tlast  <= 1'b0;
              end
            end else begin
              r_line      <= r_line + 12'd1;
              r_src_tlast <= (r_line + 12'd1 == r_pkt_lines);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_clr)           r_idx <= '0;
      else if (w_src_beat) r_idx <= r_idx + 16'd1;
    end
  end

  assign w_word        = {~r_idx, r_idx, ~r_idx, r_idx};
  assign m_src_tdata   = {(CHDR_W/64){w_word}};
  assign m_src_tlast   = r_src_tlast;
  assign m_src_tvalid  = r_src_tvalid;
  assign m_src_tlength = r_bytes_per_pkt;
  assign s_snk_tready  = r_snk_tready;

  assign s_ctrlport_resp_ack  = r_ack;
  assign s_ctrlport_resp_data = r_resp_data;

  assign m_loop_tdata  = s_loop_tdata;
  assign m_loop_tlast  = s_loop_tlast;
  assign m_loop_tvalid = s_loop_tvalid;
  assign s_loop_tready = m_loop_tready;

  assign w_unused = ^{s_ctrlport_req_data[31:16], s_snk_tdata};

endmodule

// File: tb/tb_null_src_sink.sv
// Directed self-checking bench for null_src_sink: registers, loopback, sink, source, clear, reset.
module tb_null_src_sink;

  localparam int CHDR_W = 64;

  logic              clk, rst_n;
  logic              wr, rd;
  logic [19:0]       addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;
  logic [CHDR_W-1:0] snk_tdata, src_tdata, sloop_tdata, mloop_tdata;
  logic              snk_tlast, snk_tvalid, snk_tready;
  logic              src_tlast, src_tvalid, src_tready;
  logic [15:0]       src_tlength;
  logic              sloop_tlast, sloop_tvalid, sloop_tready;
  logic              mloop_tlast, mloop_tvalid, mloop_tready;

  logic              mon_en, mon_tready, tb_tready;
  int                n_checks, n_errors;
  int                mon_idx, mon_k, mon_pkts;
  logic              prev_stall, prev_last;
  logic [63:0]       prev_data;

  assign src_tready = mon_en ? mon_tready : tb_tready;

  null_src_sink #(.CHDR_W(CHDR_W), .NSPC(2), .ITEM_W(32), .MTU(10)) dut (
    .rfnoc_chdr_clk(clk), .rfnoc_chdr_rst_n(rst_n),
    .s_ctrlport_req_wr(wr), .s_ctrlport_req_rd(rd),
    .s_ctrlport_req_addr(addr), .s_ctrlport_req_data(wdata),
    .s_ctrlport_resp_ack(ack), .s_ctrlport_resp_data(rdata),
    .s_snk_tdata(snk_tdata), .s_snk_tlast(snk_tlast), .s_snk_tvalid(snk_tvalid), .s_snk_tready(snk_tready),
    .m_src_tdata(src_tdata), .m_src_tlast(src_tlast), .m_src_tvalid(src_tvalid), .m_src_tready(src_tready),
    .m_src_tlength(src_tlength),
    .s_loop_tdata(sloop_tdata), .s_loop_tlast(sloop_tlast), .s_loop_tvalid(sloop_tvalid), .s_loop_tready(sloop_tready),
    .m_loop_tdata(mloop_tdata), .m_loop_tlast(mloop_tlast), .m_loop_tvalid(mloop_tvalid), .m_loop_tready(mloop_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [15:0] i);
    return {~i, i, ~i, i};
  endfunction

  task automatic ctrl_wr(input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
    check("wr_ack", 64'(ack), 64'd1);
  endtask

  task automatic ctrl_rd(input logic [19:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    check("rd_ack", 64'(ack), 64'd1);
    d = rdata;
  endtask

  task automatic rd_check(input string tag, input logic [19:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ctrl_rd(a, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  // Source monitor: random backpressure, pattern/tlast/hold checks against its own line index.
  initial begin
    mon_tready = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    mon_idx = 0; mon_k = 0; mon_pkts = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_stall) begin
          check("src_hold_data", src_tdata, prev_data);
          check("src_hold_last", 64'(src_tlast), 64'(prev_last));
        end
        mon_tready = ($urandom_range(3) != 0);
        if (src_tvalid && mon_tready) begin
          check("src_data", src_tdata, pat(16'(mon_idx)));
          check("src_last", 64'(src_tlast), 64'(mon_k == 99));
          mon_idx++;
          if (mon_k == 99) begin mon_k = 0; mon_pkts++; end
          else mon_k++;
        end
        prev_stall = src_tvalid && !mon_tready;
        prev_data  = src_tdata;
        prev_last  = src_tlast;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    snk_tdata = '0; snk_tlast = 1'b0; snk_tvalid = 1'b0;
    sloop_tdata = '0; sloop_tlast = 1'b0; sloop_tvalid = 1'b0;
    mloop_tready = 1'b1; tb_tready = 1'b0; mon_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_src_tvalid", 64'(src_tvalid), 64'd0);
    check("rst_snk_tready", 64'(snk_tready), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("snk_tready", 64'(snk_tready), 64'd1);
    rd_check("ctrl_status", 20'h00, 32'h0220_0000);
    rd_check("bytes_rst", 20'h08, 32'd8);
    check("tlength_rst", 64'(src_tlength), 64'd8);
    @(negedge clk);
    check("idle_resp_data", 64'(rdata), 64'd0);
    check("idle_ack", 64'(ack), 64'd0);

    // Loopback
    for (int p = 0; p < 50; p++)
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        sloop_tvalid = 1'b1;
        sloop_tlast  = (k == 99);
        sloop_tdata  = {$urandom, $urandom};
        #1;
        check("loop_data", mloop_tdata, sloop_tdata);
        if (k == 99) check("loop_last", 64'({mloop_tvalid, mloop_tlast}), 64'd3);
      end
    @(negedge clk);
    sloop_tvalid = 1'b0; sloop_tlast = 1'b0;
    mloop_tready = 1'b0;
    #1 check("loop_tready", 64'(sloop_tready), 64'd0);
    mloop_tready = 1'b1;
    rd_check("loop_lines", 20'h30, 32'd5000);
    rd_check("loop_pkts", 20'h38, 32'd50);
    rd_check("src_lines0", 20'h20, 32'd0);
    rd_check("snk_lines0", 20'h10, 32'd0);
    rd_check("snk_pkts0", 20'h18, 32'd0);

    // Sink
    for (int p = 0; p < 50; p++)
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        snk_tvalid = 1'b1; snk_tlast = (k == 99); snk_tdata = {$urandom, $urandom};
      end
    @(negedge clk);
    snk_tvalid = 1'b0; snk_tlast = 1'b0;
    rd_check("snk_lines", 20'h10, 32'd5000);
    rd_check("snk_pkts", 20'h18, 32'd50);
    rd_check("loop_lines_kept", 20'h30, 32'd5000);
    rd_check("loop_pkts_kept", 20'h38, 32'd50);

    // Source
    ctrl_wr(20'h04, 32'd99);
    ctrl_wr(20'h08, 32'd808);
    mon_en = 1'b1;
    ctrl_wr(20'h00, 32'h2);
    repeat (500) @(negedge clk);
    ctrl_wr(20'h00, 32'h0);
    for (int c = 0; c < 3000 && src_tvalid; c++) @(negedge clk);
    check("src_stop_timeout", 64'(src_tvalid), 64'd0);
    @(negedge clk);
    mon_en = 1'b0;
    check("src_whole_pkts", 64'(mon_idx), 64'(mon_pkts * 100));
    check("src_pkts_min", 64'(mon_pkts >= 2), 64'd1);
    rd_check("src_pkts", 20'h28, 32'(mon_pkts));
    rd_check("src_lines", 20'h20, 32'(mon_idx));
    check("tlength", 64'(src_tlength), 64'd808);

    // Clear
    ctrl_wr(20'h00, 32'h1);
    for (int a = 'h10; a <= 'h3C; a += 4) rd_check("clr_cnt", 20'(a), 32'd0);
    rd_check("ctrl_after_clr", 20'h00, 32'h0220_0000);

    // 32-bit carry into the HI word, read via LO then HI
    @(negedge clk);
    force dut.r_snk_line_cnt = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    release dut.r_snk_line_cnt;
    snk_tvalid = 1'b1;
    @(negedge clk);
    snk_tvalid = 1'b0;
    rd_check("wrap_lo", 20'h10, 32'd0);
    rd_check("wrap_hi", 20'h14, 32'd1);
    rd_check("wrap_pkt", 20'h18, 32'd0);

    // Unmapped
    ctrl_wr(20'h40, 32'hDEAD_BEEF);
    rd_check("unmapped_40", 20'h40, 32'd0);
    rd_check("unmapped_0c", 20'h0C, 32'd0);

    // Reset in the middle of a source packet
    ctrl_wr(20'h04, 32'd9);
    tb_tready = 1'b1;
    ctrl_wr(20'h00, 32'h2);
    repeat (3) @(negedge clk);
    check("mid_tvalid", 64'(src_tvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_tvalid", 64'(src_tvalid), 64'd0);
    check("async_tlast", 64'(src_tlast), 64'd0);
    check("async_snk_tready", 64'(snk_tready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tvalid", 64'(src_tvalid), 64'd0);
    rd_check("post_rst_lines", 20'h04, 32'd0);
    rd_check("post_rst_ctrl", 20'h00, 32'h0220_0000);
    ctrl_wr(20'h00, 32'h2);
    @(negedge clk);
    d = src_tdata;
    check("restart_tvalid", 64'(src_tvalid), 64'd1);
    check("restart_data", d, 64'hFFFF_0000_FFFF_0000);
    check("restart_tlast", 64'(src_tlast), 64'd1);
    ctrl_wr(20'h00, 32'h0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
